// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file with a per-register ready scoreboard.
// Registered reads, commit-gated writes, optional write-first bypass; register 0 reads as zero.
module phys_reg_file_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int N_READ  = 3,
  parameter int N_WRITE = 2,
  parameter int BYPASS  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        commitAllow,
  input  logic [N_READ-1:0]           readAck,
  input  logic [N_READ*ADDR_W-1:0]    readSelect,
  input  logic [N_WRITE-1:0]          writeAck,
  input  logic [N_WRITE*ADDR_W-1:0]   writeSelect,
  input  logic [N_WRITE*DATA_W-1:0]   writeData,
  input  logic [N_WRITE-1:0]          allocAck,
  input  logic [N_WRITE*ADDR_W-1:0]   allocSelect,
  output logic [N_READ*DATA_W-1:0]    readData,
  output logic [N_READ-1:0]           readReady
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        regFile [DEPTH];
  logic [DEPTH-1:0]         readyBits;
  logic [N_WRITE-1:0]       writeValid;
  logic [N_WRITE-1:0]       allocValid;
  logic [N_READ*DATA_W-1:0] nextData;
  logic [N_READ-1:0]        nextReady;

  // Writes and allocations to register 0 are dropped, which keeps its ready bit pinned at 1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    writeValid = '0;
    allocValid = '0;
    for (int j = 0; j < N_WRITE; j++) begin
      writeValid[j] = en && commitAllow && writeAck[j] &&
                      (writeSelect[j*ADDR_W +: ADDR_W] != '0);
      allocValid[j] = en && allocAck[j] && (allocSelect[j*ADDR_W +: ADDR_W] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: this storage array is reset on purpose because it must read back as zero after reset.
      for (int i = 0; i < DEPTH; i++) regFile[i] <= '0;
    end else begin
      // NOTE: non-blocking updates in ascending port order make the highest port win a conflict.
      for (int j = 0; j < N_WRITE; j++)
        if (writeValid[j]) regFile[writeSelect[j*ADDR_W +: ADDR_W]] <= writeData[j*DATA_W +: DATA_W];
    end
  end

  // Allocation is applied after the write so a new producer leaves the register not-ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      readyBits <= '1;
    end else begin
      for (int j = 0; j < N_WRITE; j++)
        if (writeValid[j]) readyBits[writeSelect[j*ADDR_W +: ADDR_W]] <= 1'b1;
      for (int j = 0; j < N_WRITE; j++)
        if (allocValid[j]) readyBits[allocSelect[j*ADDR_W +: ADDR_W]] <= 1'b0;
    end
  end

  always_comb begin
    nextData  = '0;
    nextReady = '0;
    for (int k = 0; k < N_READ; k++) begin
      if (readAck[k]) begin
        if (readSelect[k*ADDR_W +: ADDR_W] == '0) begin
          nextReady[k] = 1'b1;
        end else begin
          nextData[k*DATA_W +: DATA_W] = regFile[readSelect[k*ADDR_W +: ADDR_W]];
          nextReady[k]                 = readyBits[readSelect[k*ADDR_W +: ADDR_W]];
          if (BYPASS != 0) begin
            for (int j = 0; j < N_WRITE; j++) begin
              if (writeValid[j] &&
                  writeSelect[j*ADDR_W +: ADDR_W] == readSelect[k*ADDR_W +: ADDR_W]) begin
                nextData[k*DATA_W +: DATA_W] = writeData[j*DATA_W +: DATA_W];
                nextReady[k]                 = 1'b1;
              end
            end
            // A same-cycle allocation only overrides readiness of bypassed data.
            for (int j = 0; j < N_WRITE; j++) begin
              for (int m = 0; m < N_WRITE; m++) begin
                if (allocValid[j] && writeValid[m] &&
                    allocSelect[j*ADDR_W +: ADDR_W] == readSelect[k*ADDR_W +: ADDR_W] &&
                    writeSelect[m*ADDR_W +: ADDR_W] == readSelect[k*ADDR_W +: ADDR_W])
                  nextReady[k] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      readData  <= '0;
      readReady <= '0;
    end else if (en) begin
      readData  <= nextData;
      readReady <= nextReady;
    end
  end

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Vector-table bench for phys_reg_file_mp: one write-first and one read-old instance share stimulus.
module tb_phys_reg_file_mp;

  typedef struct {
    string            name;
    logic             rst, en, ca;
    logic [2:0]       rAck;
    logic [2:0][5:0]  rSel;
    logic [1:0]       wAck;
    logic [1:0][5:0]  wSel;
    logic [1:0][31:0] wData;
    logic [1:0]       aAck;
    logic [1:0][5:0]  aSel;
    logic [2:0][31:0] expD;
    logic [2:0]       expR;
    logic [2:0][31:0] altD;
    logic [2:0]       altR;
    bit               altSet;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        commitAllow = 1'b0;
  logic [2:0]  readAck = '0;
  logic [17:0] readSelect = '0;
  logic [1:0]  writeAck = '0;
  logic [11:0] writeSelect = '0;
  logic [63:0] writeData = '0;
  logic [1:0]  allocAck = '0;
  logic [11:0] allocSelect = '0;
  logic [95:0] readDataBy, readDataNb;
  logic [2:0]  readReadyBy, readReadyNb;

  int total = 0;
  int bad = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  phys_reg_file_mp #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .en(en), .commitAllow(commitAllow),
    .readAck(readAck), .readSelect(readSelect),
    .writeAck(writeAck), .writeSelect(writeSelect), .writeData(writeData),
    .allocAck(allocAck), .allocSelect(allocSelect),
    .readData(readDataBy), .readReady(readReadyBy)
  );

  phys_reg_file_mp #(.BYPASS(0)) dutNb (
    .clk(clk), .reset(reset), .en(en), .commitAllow(commitAllow),
    .readAck(readAck), .readSelect(readSelect),
    .writeAck(writeAck), .writeSelect(writeSelect), .writeData(writeData),
    .allocAck(allocAck), .allocSelect(allocSelect),
    .readData(readDataNb), .readReady(readReadyNb)
  );

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic vec_t idle(input string n);
    vec_t v;
    v.name = n; v.rst = 1'b1; v.en = 1'b1; v.ca = 1'b1;
    v.rAck = '0; v.rSel = '0;
    v.wAck = '0; v.wSel = '0; v.wData = '0;
    v.aAck = '0; v.aSel = '0;
    v.expD = '0; v.expR = '0;
    v.altD = '0; v.altR = '0; v.altSet = 1'b0;
    return v;
  endfunction

  task automatic add(input vec_t v);
    if (!v.altSet) begin
      v.altD = v.expD;
      v.altR = v.expR;
    end
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset       = v.rst;
    en          = v.en;
    commitAllow = v.ca;
    readAck     = v.rAck;
    readSelect  = v.rSel;
    writeAck    = v.wAck;
    writeSelect = v.wSel;
    writeData   = v.wData;
    allocAck    = v.aAck;
    allocSelect = v.aSel;
  endtask

  task automatic checkOut();
    vec_t e;
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_data%0d", e.name, k), readDataBy[k*32 +: 32], e.expD[k]);
      check($sformatf("%s_ready%0d", e.name, k), {31'd0, readReadyBy[k]}, {31'd0, e.expR[k]});
      check($sformatf("%s_nb_data%0d", e.name, k), readDataNb[k*32 +: 32], e.altD[k]);
      check($sformatf("%s_nb_ready%0d", e.name, k), {31'd0, readReadyNb[k]}, {31'd0, e.altR[k]});
    end
  endtask

  initial begin
    vec_t v;

    // Reset wins over a concurrent write, allocation and read.
    v = idle("reset"); v.rst = 1'b0;
    v.wAck = 2'b01; v.wSel[0] = 6'd7; v.wData[0] = 32'h99;
    v.aAck = 2'b10; v.aSel[1] = 6'd8;
    v.rAck = 3'b111; v.rSel = {6'd5, 6'd5, 6'd5};
    add(v);

    v = idle("t1_read_r5"); v.rAck = 3'b111; v.rSel = {6'd5, 6'd5, 6'd5}; v.expR = 3'b111; add(v);

    v = idle("t2_write_r7"); v.wAck = 2'b01; v.wSel[0] = 6'd7; v.wData[0] = 32'hDEADBEEF; add(v);
    v = idle("t2_read_r7"); v.rAck = 3'b100; v.rSel[2] = 6'd7;
    v.expD[2] = 32'hDEADBEEF; v.expR = 3'b100; add(v);

    v = idle("t3_gated"); v.ca = 1'b0; v.wAck = 2'b01; v.wSel[0] = 6'd9; v.wData[0] = 32'h55; add(v);
    v = idle("t3_read_r9"); v.rAck = 3'b101; v.rSel[0] = 6'd9; v.rSel[2] = 6'd7;
    v.expD[2] = 32'hDEADBEEF; v.expR = 3'b101; add(v);
    // With en low nothing moves: outputs keep the previous row's values.
    v = idle("t3_hold"); v.en = 1'b0; v.wAck = 2'b01; v.wSel[0] = 6'd9; v.wData[0] = 32'h55;
    v.aAck = 2'b01; v.aSel[0] = 6'd7; v.rAck = 3'b111; v.rSel = {6'd9, 6'd9, 6'd9};
    v.expD[2] = 32'hDEADBEEF; v.expR = 3'b101; add(v);
    v = idle("t3_after_hold"); v.rAck = 3'b011; v.rSel[0] = 6'd9; v.rSel[1] = 6'd7;
    v.expD[1] = 32'hDEADBEEF; v.expR = 3'b011; add(v);

    v = idle("t5_alloc"); v.ca = 1'b0; v.aAck = 2'b01; v.aSel[0] = 6'd12; add(v);
    v = idle("t5_read_busy"); v.rAck = 3'b010; v.rSel[1] = 6'd12; add(v);
    v = idle("t5_write"); v.wAck = 2'b10; v.wSel[1] = 6'd12; v.wData[1] = 32'h1; add(v);
    v = idle("t5_read_ready"); v.rAck = 3'b010; v.rSel[1] = 6'd12;
    v.expD[1] = 32'h1; v.expR = 3'b010; add(v);
    v = idle("t5_alloc_write"); v.aAck = 2'b01; v.aSel[0] = 6'd12;
    v.wAck = 2'b01; v.wSel[0] = 6'd12; v.wData[0] = 32'h2; add(v);
    v = idle("t5_read_new"); v.rAck = 3'b010; v.rSel[1] = 6'd12; v.expD[1] = 32'h2; add(v);

    v = idle("t6_r0"); v.wAck = 2'b11; v.wSel = '0; v.wData = {32'hFFFFFFFF, 32'hFFFFFFFF};
    v.aAck = 2'b11; v.aSel = '0; v.rAck = 3'b111; v.rSel = '0; v.expR = 3'b111; add(v);
    v = idle("t6_gating"); v.rAck = 3'b001; v.rSel = {6'd12, 6'd7, 6'd0}; v.expR = 3'b001; add(v);

    v = idle("t4_pre"); v.wAck = 2'b01; v.wSel[0] = 6'd3; v.wData[0] = 32'hA5; add(v);
    v = idle("t4_conflict"); v.wAck = 2'b11; v.wSel = {6'd3, 6'd3}; v.wData = {32'h22, 32'h11};
    v.rAck = 3'b001; v.rSel[0] = 6'd3; v.expD[0] = 32'h22; v.expR = 3'b001;
    v.altD = '0; v.altD[0] = 32'hA5; v.altR = 3'b001; v.altSet = 1'b1; add(v);
    v = idle("t4_follow"); v.rAck = 3'b001; v.rSel[0] = 6'd3;
    v.expD[0] = 32'h22; v.expR = 3'b001; add(v);

    v = idle("byp_alloc"); v.wAck = 2'b10; v.wSel[1] = 6'd20; v.wData[1] = 32'h77;
    v.aAck = 2'b01; v.aSel[0] = 6'd20; v.rAck = 3'b001; v.rSel[0] = 6'd20;
    v.expD[0] = 32'h77; v.expR = 3'b000;
    v.altD = '0; v.altR = 3'b001; v.altSet = 1'b1; add(v);
    v = idle("byp_follow"); v.rAck = 3'b001; v.rSel[0] = 6'd20; v.expD[0] = 32'h77; add(v);

    v = idle("mixed_ports"); v.rAck = 3'b111; v.rSel = {6'd12, 6'd3, 6'd7};
    v.expD = {32'h2, 32'h22, 32'hDEADBEEF}; v.expR = 3'b011; add(v);

    // Mid-stream reset: concurrent write and allocation must be discarded.
    v = idle("mid_reset"); v.rst = 1'b0; v.wAck = 2'b10; v.wSel[1] = 6'd7; v.wData[1] = 32'h1234;
    v.aAck = 2'b01; v.aSel[0] = 6'd3; v.rAck = 3'b111; v.rSel = {6'd12, 6'd3, 6'd7}; add(v);
    v = idle("post_reset"); v.rAck = 3'b111; v.rSel = {6'd12, 6'd3, 6'd7}; v.expR = 3'b111; add(v);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) checkOut();
      drive(tbl[i]);
      sb.push_back(tbl[i]);
    end
    @(negedge clk);
    checkOut();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
